fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 8-bit pipelined core. It owns the PC and selects the next PC from the reset vector, interrupt vector, branch target, RET address or PC+1. It drives the instruction-memory address and latches the fetched byte plus any trailing immediate into IF/ID. Its outputs feed the decode stage and the Control_unit, and it obeys that unit's PC_Write_En, IF_ID_Write_En, Inject_Bubble and Inject_Int.

---
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, picks the next PC and fills the IF/ID register.
// BOOT loads the PC from the reset vector. RUN handles redirects, immediate capture, stalls and bubbles.
module fetch_stage #(
  parameter int              ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PC_Write_En,
  input  logic              IF_ID_Write_En,
  input  logic              Inject_Bubble,
  input  logic              Inject_Int,
  input  logic              Branch_Taken,
  input  logic [ADDR_W-1:0] Branch_Target,
  input  logic              Ret_Taken,
  input  logic [ADDR_W-1:0] Ret_Addr,
  output logic [ADDR_W-1:0] IMem_Addr,
  input  logic [7:0]        IMem_Data,
  output logic [3:0]        IF_ID_Opcode,
  output logic [1:0]        IF_ID_Ra,
  output logic [1:0]        IF_ID_Rb,
  output logic [ADDR_W-1:0] IF_ID_PC_Plus1,
  output logic [7:0]        IF_ID_Imm,
  output logic              IF_ID_Valid,
  output logic [ADDR_W-1:0] Int_Ret_PC
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] vector_pc;
  logic              redirect;

  assign pc_plus1  = pc + ADDR_W'(1);
  assign vector_pc = ADDR_W'(IMem_Data);
  assign redirect  = Ret_Taken || Branch_Taken || Inject_Int;

  assign IMem_Addr = (state == BOOT) ? RESET_VEC :
                     (Inject_Int     ? INT_VEC : pc);

  // A redirect flushes IF/ID but keeps Imm and PC_Plus1. A lost lower-priority redirect must be re-asserted upstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= BOOT;
      pc             <= '0;
      IF_ID_Opcode   <= '0;
      IF_ID_Ra       <= '0;
      IF_ID_Rb       <= '0;
      IF_ID_PC_Plus1 <= '0;
      IF_ID_Imm      <= '0;
      IF_ID_Valid    <= 1'b0;
      Int_Ret_PC     <= '0;
    end else begin
      case (state)
        BOOT: begin
          pc           <= vector_pc;
          IF_ID_Opcode <= '0;
          IF_ID_Ra     <= '0;
          IF_ID_Rb     <= '0;
          IF_ID_Valid  <= 1'b0;
          state        <= RUN;
        end
        RUN: begin
          if (Ret_Taken) begin
            pc <= Ret_Addr;
          end else if (Branch_Taken) begin
            pc <= Branch_Target;
          end else if (Inject_Int) begin
            pc         <= vector_pc;
            Int_Ret_PC <= pc;
          end else if (PC_Write_En) begin
            pc <= pc_plus1;
          end

          // With IF_ID_Write_En low and the PC advancing, this byte is the trailing immediate.
          if (redirect) begin
            IF_ID_Opcode <= '0;
            IF_ID_Ra     <= '0;
            IF_ID_Rb     <= '0;
            IF_ID_Valid  <= 1'b0;
          end else if (!IF_ID_Write_En) begin
            if (PC_Write_En) begin
              IF_ID_Imm <= IMem_Data;
            end
          end else if (Inject_Bubble) begin
            IF_ID_Opcode   <= '0;
            IF_ID_Ra       <= '0;
            IF_ID_Rb       <= '0;
            IF_ID_Valid    <= 1'b0;
            IF_ID_PC_Plus1 <= pc_plus1;
          end else begin
            {IF_ID_Opcode, IF_ID_Ra, IF_ID_Rb} <= IMem_Data;
            IF_ID_PC_Plus1 <= pc_plus1;
            IF_ID_Valid    <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. It uses a fixed instruction memory and a table of per-cycle
// control inputs with the expected IMem_Addr and IF/ID contents.
module tb_fetch_stage;

  logic       clk;
  logic       rst;
  logic       pc_write_en;
  logic       if_id_write_en;
  logic       inject_bubble;
  logic       inject_int;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       ret_taken;
  logic [7:0] ret_addr;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [3:0] opcode;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [7:0] pc_plus1;
  logic [7:0] imm;
  logic       valid;
  logic [7:0] int_ret_pc;

  logic [7:0] mem [256];

  int checks;
  int failures;

  typedef struct {
    logic       pcw;
    logic       ifw;
    logic       bub;
    logic       intr;
    logic       br;
    logic [7:0] bt;
    logic       rt;
    logic [7:0] ra;
    logic [7:0] addr;
    logic [7:0] ins;
    logic [7:0] pcp1;
    logic [7:0] imm;
    logic       valid;
    logic [7:0] iret;
  } vec_t;

  vec_t vecs [18];
  vec_t sb_q [$];

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .PC_Write_En    (pc_write_en),
    .IF_ID_Write_En (if_id_write_en),
    .Inject_Bubble  (inject_bubble),
    .Inject_Int     (inject_int),
    .Branch_Taken   (branch_taken),
    .Branch_Target  (branch_target),
    .Ret_Taken      (ret_taken),
    .Ret_Addr       (ret_addr),
    .IMem_Addr      (imem_addr),
    .IMem_Data      (imem_data),
    .IF_ID_Opcode   (opcode),
    .IF_ID_Ra       (ra),
    .IF_ID_Rb       (rb),
    .IF_ID_PC_Plus1 (pc_plus1),
    .IF_ID_Imm      (imm),
    .IF_ID_Valid    (valid),
    .Int_Ret_PC     (int_ret_pc)
  );

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  function automatic vec_t mk(logic pcw, logic ifw, logic bub, logic intr, logic br, logic [7:0] bt,
                              logic rt, logic [7:0] rad, logic [7:0] addr, logic [7:0] ins,
                              logic [7:0] pcp1, logic [7:0] im, logic vld, logic [7:0] iret);
    vec_t v;
    v.pcw = pcw; v.ifw = ifw; v.bub = bub; v.intr = intr; v.br = br; v.bt = bt;
    v.rt = rt; v.ra = rad; v.addr = addr; v.ins = ins; v.pcp1 = pcp1; v.imm = im;
    v.valid = vld; v.iret = iret;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pcw, input logic ifw, input logic bub, input logic intr,
                       input logic br, input logic [7:0] bt, input logic rt, input logic [7:0] rad);
    pc_write_en    = pcw;
    if_id_write_en = ifw;
    inject_bubble  = bub;
    inject_int     = intr;
    branch_taken   = br;
    branch_target  = bt;
    ret_taken      = rt;
    ret_addr       = rad;
  endtask

  // Pops the expected record that matches the edge just taken and compares all IF/ID outputs.
  task automatic check_output();
    vec_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty actual=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    check("if_id_ins",   {opcode, ra, rb}, e.ins);
    check("if_id_pcp1",  pc_plus1, e.pcp1);
    check("if_id_imm",   imm, e.imm);
    check("if_id_valid", {7'd0, valid}, {7'd0, e.valid});
    check("int_ret_pc",  int_ret_pc, e.iret);
  endtask

  // Called at a falling edge. Checks the combinational address, then the registered result after the rising edge.
  task automatic apply_stimulus(input vec_t v);
    drive(v.pcw, v.ifw, v.bub, v.intr, v.br, v.bt, v.rt, v.ra);
    sb_q.push_back(v);
    #1;
    check("imem_addr", imem_addr, v.addr);
    @(posedge clk);
    #1;
    check_output();
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    check("rst_imem_addr", imem_addr, 8'h00);
    check("rst_ins",       {opcode, ra, rb}, 8'h00);
    check("rst_pcp1",      pc_plus1, 8'h00);
    check("rst_imm",       imm, 8'h00);
    check("rst_valid",     {7'd0, valid}, 8'h00);
    check("rst_int_ret",   int_ret_pc, 8'h00);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst      = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'hE0;
    mem[8'h10] = 8'h21; mem[8'h11] = 8'hC1; mem[8'h12] = 8'h5A; mem[8'h13] = 8'h33;
    mem[8'h14] = 8'h44; mem[8'h15] = 8'h55; mem[8'h16] = 8'h66; mem[8'h40] = 8'h77;
    mem[8'h80] = 8'h88; mem[8'hE0] = 8'hAB; mem[8'hE1] = 8'hCD; mem[8'hFF] = 8'hF1;

    //              pcw ifw bub int br  bt     rt  ra      addr   ins    pcp1   imm    vld iret
    vecs[0]  = mk(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    vecs[1]  = mk(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h10, 8'h21, 8'h11, 8'h00, 1, 8'h00);
    vecs[2]  = mk(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h11, 8'hC1, 8'h12, 8'h00, 1, 8'h00);
    vecs[3]  = mk(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h12, 8'hC1, 8'h12, 8'h5A, 1, 8'h00);
    vecs[4]  = mk(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h13, 8'h33, 8'h14, 8'h5A, 1, 8'h00);
    vecs[5]  = mk(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h14, 8'h33, 8'h14, 8'h5A, 1, 8'h00);
    vecs[6]  = mk(0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h14, 8'h33, 8'h14, 8'h5A, 1, 8'h00);
    vecs[7]  = mk(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h14, 8'h33, 8'h14, 8'h5A, 1, 8'h00);
    vecs[8]  = mk(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h14, 8'h44, 8'h15, 8'h5A, 1, 8'h00);
    vecs[9]  = mk(1, 1, 1, 0, 0, 8'h00, 0, 8'h00, 8'h15, 8'h00, 8'h16, 8'h5A, 0, 8'h00);
    vecs[10] = mk(1, 1, 0, 0, 1, 8'h40, 1, 8'h80, 8'h16, 8'h00, 8'h16, 8'h5A, 0, 8'h00);
    vecs[11] = mk(1, 0, 0, 0, 1, 8'h40, 0, 8'h00, 8'h80, 8'h00, 8'h16, 8'h5A, 0, 8'h00);
    vecs[12] = mk(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h40, 8'h77, 8'h41, 8'h5A, 1, 8'h00);
    vecs[13] = mk(1, 1, 0, 1, 0, 8'h00, 0, 8'h00, 8'h01, 8'h00, 8'h41, 8'h5A, 0, 8'h41);
    vecs[14] = mk(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'hE0, 8'hAB, 8'hE1, 8'h5A, 1, 8'h41);
    vecs[15] = mk(1, 1, 0, 1, 1, 8'hFF, 0, 8'h00, 8'h01, 8'h00, 8'hE1, 8'h5A, 0, 8'h41);
    vecs[16] = mk(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'hFF, 8'hF1, 8'h00, 8'h5A, 1, 8'h41);
    vecs[17] = mk(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h10, 8'h01, 8'h5A, 1, 8'h41);

    @(negedge clk);
    #1;
    check_reset_values();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 18; i++) apply_stimulus(vecs[i]);

    // Reset lands mid-capture at PC=01: the capture is discarded and every output clears asynchronously.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values();
    @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    rst = 1'b1;
    #1;
    check("reboot_addr", imem_addr, 8'h00);
    @(posedge clk);
    #1;
    check("reboot_valid", {7'd0, valid}, 8'h00);
    @(negedge clk);
    #1;
    check("reboot_pc", imem_addr, 8'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
